pll_lock_supervisor: RTL and testbench

Drives the reset input of a clock-generator PLL and consumes its lock indication, both on the PLL reference clock. Sequences PLL reset and lock acquisition, enforces a lock timeout with bounded retries, and requires a lock-stability window. Only then does it release the core reset. Sits beside each PLL instance in the sys layer; its core_reset feeds the emulation core's reset tree.

---
 rtl/pll_sup_pkg.sv | 20 ++
 rtl/pll_lock_sync.sv | 30 +++
 rtl/pll_lock_supervisor.sv | 158 +++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and elaboration helpers for the PLL lock supervisor.
// Imported by the supervisor top.
package pll_sup_pkg;

    typedef enum logic [2:0] {
        RESET_PLL = 3'd0,
        WAIT_LOCK = 3'd1,
        STABILIZE = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } sup_state_e;

    // Largest of three cycle counts; sizes the shared phase counter.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchronizer that brings the asynchronous PLL lock flag into the refclk domain.
// SYNC_STAGES must be at least 2.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic [SYNC_STAGES-1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], d};
    end

    // NOTE: every synchronizer flop is reset to 0 so a stale lock is never seen just after rst_n.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences PLL reset, lock acquisition with timeout/retry, and a lock-stability window
// before releasing the core reset. Everything runs on the PLL reference clock.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int STARTUP_CYCLES = 16,
    parameter int LOCK_TIMEOUT   = 500000,
    parameter int STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES    = 3,
    parameter int SYNC_STAGES    = 2
) (
    input  logic                               refclk,
    input  logic                               rst_n,
    input  logic                               locked_in,
    input  logic                               force_relock,
    output logic                               pll_rst,
    output logic                               core_reset,
    output logic                               ready,
    output logic                               fault,
    output logic                               lost_lock,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count
);

    localparam int CNT_MAX = max3(STARTUP_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   STARTUP_LAST = CNT_W'(STARTUP_CYCLES - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RETRY_W-1:0] RETRY_LIMIT  = RETRY_W'(MAX_RETRIES);

    sup_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic               pll_rst_q, pll_rst_d;
    logic               core_reset_q, core_reset_d;
    logic               ready_q, ready_d;
    logic               fault_q, fault_d;
    logic               lost_lock_q, lost_lock_d;
    logic               locked_s;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked_in),
        .q     (locked_s)
    );

    always_comb begin
        // NOTE: every _d gets a default first so no path through the case infers a latch.
        state_d     = state_q;
        cnt_d       = cnt_q;
        retry_d     = retry_q;
        lost_lock_d = 1'b0;

        unique case (state_q)
            RESET_PLL: begin
                if (cnt_q == STARTUP_LAST) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                // A lock arriving on the timeout cycle still wins.
                if (locked_s) begin
                    state_d = STABILIZE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    cnt_d = '0;
                    if (retry_q == RETRY_LIMIT) begin
                        state_d = FAULT;
                    end else begin
                        state_d = RESET_PLL;
                        retry_d = retry_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            STABILIZE: begin
                // A lock glitch restarts the wait without consuming a retry.
                if (!locked_s) begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = RUN;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_d     = RESET_PLL;
                    cnt_d       = '0;
                    lost_lock_d = 1'b1;
                end
            end
            FAULT: begin
                state_d = FAULT;
            end
            default: begin
                state_d = RESET_PLL;
                cnt_d   = '0;
            end
        endcase

        if (force_relock) begin
            state_d     = RESET_PLL;
            cnt_d       = '0;
            retry_d     = '0;
            lost_lock_d = 1'b0;
        end

        // Outputs are decoded from the next state so the registered copies track state_q exactly.
        pll_rst_d    = (state_d == RESET_PLL) || (state_d == FAULT);
        core_reset_d = (state_d != RUN);
        ready_d      = (state_d == RUN);
        fault_d      = (state_d == FAULT);
    end

    // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= RESET_PLL;
            cnt_q        <= '0;
            retry_q      <= '0;
            pll_rst_q    <= 1'b1;
            core_reset_q <= 1'b1;
            ready_q      <= 1'b0;
            fault_q      <= 1'b0;
            lost_lock_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            retry_q      <= retry_d;
            pll_rst_q    <= pll_rst_d;
            core_reset_q <= core_reset_d;
            ready_q      <= ready_d;
            fault_q      <= fault_d;
            lost_lock_q  <= lost_lock_d;
        end
    end

    assign pll_rst     = pll_rst_q;
    assign core_reset  = core_reset_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign lost_lock   = lost_lock_q;
    assign retry_count = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: cycle-stamped vector tables feed a scoreboard
// queue that is drained and compared on the falling edge of each reference-clock cycle.
module tb_pll_lock_supervisor;

    localparam int STARTUP_CYCLES = 4;
    localparam int LOCK_TIMEOUT   = 20;
    localparam int STABLE_CYCLES  = 8;
    localparam int MAX_RETRIES    = 2;
    localparam int SYNC_STAGES    = 2;

    // stim = {locked_in, force_relock}; expv = {pll_rst, core_reset, ready, fault, lost_lock, retry_count[1:0]}
    typedef struct packed {
        int         cyc;
        logic [1:0] stim;
        logic [6:0] expv;
    } vec_t;

    logic       refclk = 1'b0;
    logic       rst_n;
    logic       locked_in;
    logic       force_relock;
    logic       pll_rst;
    logic       core_reset;
    logic       ready;
    logic       fault;
    logic       lost_lock;
    logic [1:0] retry_count;
    logic [6:0] outs;

    int checks = 0;
    int errors = 0;

    vec_t vq[$];
    vec_t sb[$];

    // Power-up with lock at cycle 10, then a lock loss in RUN and a relock.
    vec_t run_a [16] = '{
        '{0,   2'b00, 7'b1100000},
        '{3,   2'b00, 7'b1100000},
        '{4,   2'b00, 7'b0100000},
        '{10,  2'b10, 7'b0100000},
        '{20,  2'b10, 7'b0100000},
        '{21,  2'b10, 7'b0010000},
        '{30,  2'b00, 7'b0010000},
        '{32,  2'b00, 7'b0010000},
        '{33,  2'b00, 7'b1100100},
        '{34,  2'b00, 7'b1100000},
        '{36,  2'b00, 7'b1100000},
        '{37,  2'b00, 7'b0100000},
        '{40,  2'b10, 7'b0100000},
        '{50,  2'b10, 7'b0100000},
        '{51,  2'b10, 7'b0010000},
        '{55,  2'b10, 7'b0010000}
    };

    // Recovery from FAULT by force_relock, then force_relock in RUN and inside RESET_PLL.
    vec_t run_b [14] = '{
        '{80,  2'b11, 7'b1101010},
        '{81,  2'b10, 7'b1100000},
        '{84,  2'b10, 7'b1100000},
        '{85,  2'b10, 7'b0100000},
        '{93,  2'b10, 7'b0100000},
        '{94,  2'b10, 7'b0010000},
        '{100, 2'b11, 7'b0010000},
        '{101, 2'b10, 7'b1100000},
        '{103, 2'b11, 7'b1100000},
        '{104, 2'b10, 7'b1100000},
        '{107, 2'b10, 7'b1100000},
        '{108, 2'b10, 7'b0100000},
        '{116, 2'b10, 7'b0100000},
        '{117, 2'b10, 7'b0010000}
    };

    // One timeout (retry 1), lock at 30, a 3-cycle glitch in STABILIZE at 34..36.
    vec_t run_c [10] = '{
        '{0,   2'b00, 7'b1100000},
        '{24,  2'b00, 7'b1100001},
        '{28,  2'b00, 7'b0100001},
        '{30,  2'b10, 7'b0100001},
        '{34,  2'b00, 7'b0100001},
        '{37,  2'b10, 7'b0100001},
        '{39,  2'b10, 7'b0100001},
        '{41,  2'b10, 7'b0100001},
        '{47,  2'b10, 7'b0100001},
        '{48,  2'b10, 7'b0010000}
    };

    // Lock becomes visible on the very cycle the first timeout expires.
    vec_t run_d [5] = '{
        '{21,  2'b10, 7'b0100000},
        '{23,  2'b10, 7'b0100000},
        '{24,  2'b10, 7'b0100000},
        '{31,  2'b10, 7'b0100000},
        '{32,  2'b10, 7'b0010000}
    };

    pll_lock_supervisor #(
        .STARTUP_CYCLES (STARTUP_CYCLES),
        .LOCK_TIMEOUT   (LOCK_TIMEOUT),
        .STABLE_CYCLES  (STABLE_CYCLES),
        .MAX_RETRIES    (MAX_RETRIES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .locked_in    (locked_in),
        .force_relock (force_relock),
        .pll_rst      (pll_rst),
        .core_reset   (core_reset),
        .ready        (ready),
        .fault        (fault),
        .lost_lock    (lost_lock),
        .retry_count  (retry_count)
    );

    always #5 refclk = ~refclk;

    assign outs = {pll_rst, core_reset, ready, fault, lost_lock, retry_count};

    task automatic check(input string name, input logic [6:0] act, input logic [6:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %b required %b (pll_rst core_reset ready fault lost_lock retry[1:0])",
                     name, act, expv);
        end
    endtask

    // Holds reset for a few edges, then releases it 1 ns after an edge: that cycle is cycle 0.
    task automatic start_run();
        rst_n        = 1'b0;
        locked_in    = 1'b0;
        force_relock = 1'b0;
        vq.delete();
        sb.delete();
        repeat (3) @(posedge refclk);
        #1 rst_n = 1'b1;
    endtask

    task automatic run_vecs(input string tag, input int last);
        vec_t v;
        for (int c = 0; c <= last; c++) begin
            while (vq.size() > 0 && vq[0].cyc <= c) begin
                v = vq.pop_front();
                {locked_in, force_relock} = v.stim;
                sb.push_back(v);
            end
            @(negedge refclk);
            while (sb.size() > 0 && sb[0].cyc <= c) begin
                v = sb.pop_front();
                check($sformatf("%s cycle %0d", tag, v.cyc), outs, v.expv);
            end
            @(posedge refclk);
            #1;
        end
    endtask

    initial begin
        vec_t v;
        logic [1:0] r;
        logic       p;

        // Normal power-up, then lock loss in RUN with relock.
        start_run();
        foreach (run_a[i]) vq.push_back(run_a[i]);
        run_vecs("powerup_lostlock", 55);

        // No lock at all: three attempts then FAULT at cycle 72; ready never rises.
        start_run();
        for (int c = 0; c < 80; c++) begin
            p = (c <= 3) || (c >= 24 && c <= 27) || (c >= 48 && c <= 51) || (c >= 72);
            r = (c < 24) ? 2'd0 : (c < 48) ? 2'd1 : 2'd2;
            v.cyc  = c;
            v.stim = 2'b00;
            v.expv = {p, 1'b1, 1'b0, (c >= 72), 1'b0, r};
            vq.push_back(v);
        end
        foreach (run_b[i]) vq.push_back(run_b[i]);
        run_vecs("timeout_fault_relock", 117);

        // Lock glitch during STABILIZE after one retry.
        start_run();
        foreach (run_c[i]) vq.push_back(run_c[i]);
        run_vecs("stabilize_glitch", 48);

        // Asynchronous reset in the middle of STABILIZE, between clock edges.
        start_run();
        foreach (run_c[i]) vq.push_back(run_c[i]);
        run_vecs("pre_async_reset", 35);
        #2;
        check("stabilize before async reset", outs, 7'b0100001);
        rst_n = 1'b0;
        #1;
        check("async reset without clock edge", outs, 7'b1100000);

        // Lock and timeout land on the same cycle: lock must win.
        start_run();
        foreach (run_d[i]) vq.push_back(run_d[i]);
        run_vecs("lock_vs_timeout", 32);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
